// File: rtl/qpm_wb_pkg.sv
// Shared constants for the query-patch Wishbone loader.
// State codes, beat count and data-field layout.
package qpm_wb_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam int NB       = 7;
  localparam int BIDX_LSB = 11;
  localparam int BIDX_MSB = 13;
  localparam int BIDX_W   = BIDX_MSB - BIDX_LSB + 1;

  function automatic int nb_of(input int pw);
    return (pw + 7) / 8;
  endfunction

endpackage

// File: rtl/wb_ack_timer.sv
// Per-beat ack timeout counter.
// Expires on the LIMIT-th consecutive counting cycle.
module wb_ack_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic count_i,
  output logic expire_o
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = '0;
    else if (count_i)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expire_o = count_i && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/query_patch_wb_loader.sv
// Streams query patches into a Wishbone patch memory,
// one byte beat per bus write, with per-beat ack timeout.
module query_patch_wb_loader
  import qpm_wb_pkg::*;
#(
  parameter int DATA_WIDTH        = 11,
  parameter int PATCH_SIZE        = 5,
  parameter int ADDR_WIDTH        = 9,
  parameter int DEPTH             = 512,
  parameter int WB_ADDRESS_OFFSET = 557,
  parameter int ACK_TIMEOUT       = 255
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_i,
  input  logic                             start,
  input  logic [ADDR_WIDTH:0]              num_patches,
  input  logic                             patch_valid,
  output logic                             patch_ready,
  input  logic [DATA_WIDTH*PATCH_SIZE-1:0] patch_data,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic                             wbm_cyc_o,
  output logic                             wbm_stb_o,
  output logic                             wbm_we_o,
  output logic [3:0]                       wbm_sel_o,
  output logic [31:0]                      wbm_adr_o,
  output logic [31:0]                      wbm_dat_o,
  input  logic                             wbm_ack_i
);

  localparam int PW     = DATA_WIDTH * PATCH_SIZE;
  localparam int NBEATS = nb_of(PW);
  localparam int CW     = ADDR_WIDTH + 1;

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     pidx_q, pidx_d;
  logic [BIDX_W-1:0] bidx_q, bidx_d;
  logic [PW-1:0]     patch_q, patch_d;
  logic [NBEATS*8-1:0] pext;
  logic [7:0]        byte_d;
  logic [31:0]       dat_d;
  logic              wr_d, busy_d;
  logic              t_load, t_count, t_exp;

  assign t_count = (state_q == S_WRITE) && !wbm_ack_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pidx_d  = pidx_q;
    bidx_d  = bidx_q;
    patch_d = patch_q;
    t_load  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (state_q == S_DONE)
          state_d = S_IDLE;
        if (start) begin
          cnt_d   = (num_patches > CW'(DEPTH)) ? CW'(DEPTH) : num_patches;
          pidx_d  = '0;
          bidx_d  = '0;
          state_d = (num_patches == '0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (patch_valid) begin
          patch_d = patch_data;
          bidx_d  = '0;
          t_load  = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (wbm_ack_i) begin
          if (bidx_q != BIDX_W'(NBEATS - 1)) begin
            bidx_d  = bidx_q + BIDX_W'(1);
            state_d = S_GAP;
          end else if (pidx_q == cnt_q - CW'(1)) begin
            state_d = S_DONE;
          end else begin
            pidx_d  = pidx_q + CW'(1);
            state_d = S_WAIT;
          end
        end else if (t_exp) begin
          state_d = S_ERR;
        end
      end
      S_GAP: begin
        t_load  = 1'b1;
        state_d = S_WRITE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus fields are built from next-state values so the outputs can be registered.
  always_comb begin
    wr_d   = (state_d == S_WRITE);
    busy_d = (state_d == S_WAIT) || wr_d || (state_d == S_GAP);
    pext   = '0;
    pext[PW-1:0] = patch_d;
    byte_d = 8'(pext >> {bidx_d, 3'b000});
    dat_d  = '0;
    if (wr_d) begin
      dat_d[7:0]               = byte_d;
      dat_d[BIDX_MSB:BIDX_LSB] = bidx_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pidx_q    <= '0;
      bidx_q    <= '0;
      patch_q   <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pidx_q    <= pidx_d;
      bidx_q    <= bidx_d;
      patch_q   <= patch_d;
      wbm_cyc_o <= wr_d;
      wbm_stb_o <= wr_d;
      wbm_we_o  <= wr_d;
      wbm_sel_o <= wr_d ? 4'b0001 : 4'b0000;
      wbm_adr_o <= wr_d ? 32'(WB_ADDRESS_OFFSET) + 32'(pidx_d) : 32'd0;
      wbm_dat_o <= dat_d;
      busy      <= busy_d;
      done      <= (state_d == S_DONE);
      err       <= (state_d == S_ERR);
    end
  end

  assign patch_ready = (state_q == S_WAIT);

  wb_ack_timer #(
    .LIMIT(ACK_TIMEOUT)
  ) u_tmr (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .load_i  (t_load),
    .count_i (t_count),
    .expire_o(t_exp)
  );

endmodule

// File: tb/tb_query_patch_wb_loader.sv
// Directed bench for query_patch_wb_loader.
// Scripted Wishbone slave with latency and stall injection.
module tb_query_patch_wb_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        valid = 1'b0;
  logic [9:0]  num = '0;
  logic [54:0] pdata = '0;
  logic        ready, busy, done, err;
  logic        cyc, stb, we, ack;
  logic [3:0]  sel;
  logic [31:0] adr, dat;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  query_patch_wb_loader dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .start      (start),
    .num_patches(num),
    .patch_valid(valid),
    .patch_ready(ready),
    .patch_data (pdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .wbm_cyc_o  (cyc),
    .wbm_stb_o  (stb),
    .wbm_we_o   (we),
    .wbm_sel_o  (sel),
    .wbm_adr_o  (adr),
    .wbm_dat_o  (dat),
    .wbm_ack_i  (ack)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // slave: ack after lat wait cycles, never acks the stalled beat
  int lat = 0;
  bit drop_en = 1'b0;
  int drop_p = 0;
  int drop_b = 0;
  int wcnt = 0;
  logic stall;

  assign stall = drop_en && (adr == 32'(557 + drop_p)) &&
                 (dat[13:11] == 3'(drop_b));
  assign ack = cyc && stb && !stall && (wcnt >= lat);

  always @(posedge clk)
    wcnt <= (cyc && stb && !ack) ? wcnt + 1 : 0;

  // monitor
  logic [31:0] qadr[$];
  logic [31:0] qdat[$];
  int done_cnt = 0;
  int cyc_cycles = 0;
  int stuck = 0;
  bit pw = 1'b0;
  logic [31:0] padr, pdat;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (cyc) cyc_cycles++;
    if (cyc && stb) begin
      if (pw) begin
        check("hold_adr", 64'(adr), 64'(padr));
        check("hold_dat", 64'(dat), 64'(pdat));
      end
      if (dat[13:11] == 3'd3 && !ack) stuck++;
      if (ack) begin
        qadr.push_back(adr);
        qdat.push_back(dat);
        check("sel", 64'(sel), 64'h1);
        check("we", 64'(we), 64'h1);
      end
      pw = !ack;
      padr = adr;
      pdat = dat;
    end else begin
      pw = 1'b0;
    end
  end

  function automatic logic [54:0] pat(input int p);
    logic [63:0] v;
    v = 64'h12_3456_789A_BCDE + 64'(p) * 64'h0011_2233_4455_6677;
    return v[54:0];
  endfunction

  int acc = 0;

  task automatic drive(input int n, input int gap);
    bit ok;
    bit stop;
    logic r;
    stop = 1'b0;
    for (int p = 0; p < n && !stop; p++) begin
      repeat (gap) @(posedge clk);
      #1 valid = 1'b1;
      pdata = pat(p);
      ok = 1'b0;
      for (int t = 0; t < 60 && !ok; t++) begin
        @(negedge clk);
        r = ready;
        @(posedge clk);
        if (r) ok = 1'b1;
      end
      #1 valid = 1'b0;
      if (ok) acc++;
      else stop = 1'b1;
    end
  endtask

  task automatic kick(input int n);
    @(posedge clk);
    #1 start = 1'b1;
    num = 10'(n);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int lim, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < lim && !ok; k++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    valid = 1'b0;
    lat = 0;
    drop_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    qadr.delete();
    qdat.delete();
    acc = 0;
  endtask

  task automatic check_beats(input int n);
    logic [63:0] pv;
    logic [31:0] e;
    int idx;
    check("nbeats", 64'(qadr.size()), 64'(n * 7));
    for (int p = 0; p < n; p++) begin
      pv = 64'(pat(p));
      for (int i = 0; i < 7; i++) begin
        idx = p * 7 + i;
        if (idx < qadr.size()) begin
          e = '0;
          e[7:0] = 8'(pv >> (8 * i));
          e[13:11] = 3'(i);
          check("beat_adr", 64'(qadr[idx]), 64'(557 + p));
          check("beat_dat", 64'(qdat[idx]), 64'(e));
        end
      end
    end
  endtask

  int c;
  int d0;
  int cc0;
  bit ok;
  bit got;

  initial begin
    // reset state
    do_reset();
    @(negedge clk);
    check("rst_bus", {cyc, stb, we, sel, adr, dat}, 64'h0);
    check("rst_flags", {busy, done, err, ready}, 64'h0);

    // single patch, zero-wait slave, done latency
    d0 = done_cnt;
    @(posedge clk);
    #1 start = 1'b1;
    num = 10'd1;
    valid = 1'b1;
    pdata = pat(0);
    c = 0;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(posedge clk);
      c++;
      #1 start = 1'b0;
      if (c == 2) valid = 1'b0;
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check("t1_done_seen", 64'(got), 64'h1);
    check("t1_done_cyc", 64'(c), 64'd15);
    check_beats(1);
    repeat (3) @(negedge clk);
    check("t1_done_pulses", 64'(done_cnt - d0), 64'h1);
    check("t1_idle", {busy, ready, cyc}, 64'h0);

    // three patches, 2-cycle ack latency, gapped valid
    do_reset();
    lat = 2;
    d0 = done_cnt;
    fork
      drive(3, 3);
      begin
        kick(3);
        wait_done(600, ok);
      end
    join
    check("t2_done_seen", 64'(ok), 64'h1);
    check("t2_accepted", 64'(acc), 64'd3);
    check_beats(3);
    repeat (3) @(negedge clk);
    check("t2_done_pulses", 64'(done_cnt - d0), 64'h1);

    // missing ack on beat 3 of patch 0 -> timeout
    do_reset();
    drop_en = 1'b1;
    drop_p = 0;
    drop_b = 3;
    stuck = 0;
    got = 1'b0;
    fork
      drive(1, 0);
      begin
        kick(1);
        for (int k = 0; k < 400 && !got; k++) begin
          @(negedge clk);
          if (err) got = 1'b1;
        end
      end
    join
    check("t3_err", 64'(got), 64'h1);
    check("t3_cyc_off", {cyc, stb, busy}, 64'h0);
    check("t3_stall_cyc", 64'(stuck), 64'd255);
    check("t3_beats", 64'(qadr.size()), 64'd3);
    repeat (5) @(negedge clk);
    check("t3_err_sticky", 64'(err), 64'h1);

    // start clears err; zero-count load finishes next cycle with no bus
    drop_en = 1'b0;
    cc0 = cyc_cycles;
    d0 = done_cnt;
    kick(0);
    @(negedge clk);
    check("t4_done_next", 64'(done), 64'h1);
    check("t4_err_clr", 64'(err), 64'h0);
    repeat (3) @(negedge clk);
    check("t4_no_cyc", 64'(cyc_cycles - cc0), 64'h0);
    check("t4_one_done", 64'(done_cnt - d0), 64'h1);

    // count clamps to depth
    do_reset();
    fork
      drive(600, 0);
      begin
        kick(600);
        wait_done(9000, ok);
      end
    join
    check("t5_done_seen", 64'(ok), 64'h1);
    check("t5_accepted", 64'(acc), 64'd512);
    check_beats(512);
    check("t5_idle", {ready, busy}, 64'h0);

    // ignored start while busy, then reset mid-beat of patch 2
    do_reset();
    lat = 2;
    d0 = done_cnt;
    fork
      drive(3, 0);
      begin
        kick(3);
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        num = 10'd0;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("t6_ign_busy", 64'(busy), 64'h1);
        check("t6_ign_done", 64'(done_cnt - d0), 64'h0);
        got = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
          @(negedge clk);
          if (cyc && adr == 32'd559) got = 1'b1;
        end
        check("t6_p2_seen", 64'(got), 64'h1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_bus", {cyc, stb, we, sel, adr, dat}, 64'h0);
        check("t6_rst_flags", {busy, done, err, ready}, 64'h0);
        rst = 1'b0;
        cc0 = cyc_cycles;
        repeat (20) @(negedge clk);
        check("t6_no_retry", 64'(cyc_cycles - cc0), 64'h0);
        check("t6_idle", 64'(busy), 64'h0);
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
